// File: rtl/storage_word_bist.sv
`timescale 1ns/1ps
// rtl/storage_word_bist.sv - word read/write self-test engine for one storage SRAM block
//
// Purpose: writes pat(a) = SEED + a*STRIDE to every word, reads every word back
// and compares it, then reports START/PASS/FAIL on a 16-bit checkbits word.
// Ports:
//   clk, reset          single clock, synchronous active-high reset
//   start, block_sel    test launch pulse and status-code set select
//   mem_csb/web/addr/din registered SRAM command (active-low csb/web)
//   mem_dout            SRAM read data, valid RD_LAT cycles after a read command
//   busy, done          test in progress / one-cycle completion pulse
//   fail, fail_addr     sticky result and first mismatching address
//   checkbits           status code word

module storage_word_bist #(
  parameter int          ADDR_W = 8,
  parameter int          DATA_W = 32,
  parameter int          RD_LAT = 1,
  parameter logic [31:0] SEED   = 32'hA5A5_0F0F,
  parameter logic [31:0] STRIDE = 32'h0101_0103
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              block_sel,
  output logic              mem_csb,
  output logic              mem_web,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_din,
  input  logic [DATA_W-1:0] mem_dout,
  output logic              busy,
  output logic              done,
  output logic              fail,
  output logic [ADDR_W-1:0] fail_addr,
  output logic [15:0]       checkbits
);

  localparam logic [DATA_W-1:0] SEED_T   = DATA_W'(SEED);
  localparam logic [DATA_W-1:0] STRIDE_T = DATA_W'(STRIDE);
  localparam logic [ADDR_W-1:0] LAST     = '1;

  localparam logic [15:0] B0_START = 16'hA040;
  localparam logic [15:0] B0_FAIL  = 16'hAB40;
  localparam logic [15:0] B0_PASS  = 16'hAB41;
  localparam logic [15:0] B1_START = 16'hA020;
  localparam logic [15:0] B1_FAIL  = 16'hAB20;
  localparam logic [15:0] B1_PASS  = 16'hAB21;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WRITE,
    S_READ,
    S_DRAIN,
    S_RESULT
  } state_t;

  state_t state, nx_state;

  logic              nx_csb;
  logic              nx_web;
  logic [ADDR_W-1:0] nx_addr;
  logic [DATA_W-1:0] nx_din;
  logic              push;
  logic              flush;
  logic              blk;

  // Tag pipe: stage 0 is loaded on the edge that registers a read command,
  // so stage RD_LAT lines up with the cycle in which mem_dout is valid.
  logic [RD_LAT:0]   pipe_vld;
  logic [ADDR_W-1:0] pipe_tag [0:RD_LAT];

  logic cmp_valid;
  logic mismatch;
  logic last_ok;

  function automatic logic [DATA_W-1:0] pat(input logic [ADDR_W-1:0] a);
    return SEED_T + DATA_W'(a) * STRIDE_T;
  endfunction

  assign cmp_valid = pipe_vld[RD_LAT] && (state == S_READ || state == S_DRAIN);
  assign mismatch  = cmp_valid && (mem_dout != pat(pipe_tag[RD_LAT]));
  assign last_ok   = cmp_valid && !mismatch && (pipe_tag[RD_LAT] == LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= nx_state;
    end
  end

  // mem_addr doubles as the word counter: it always holds the address of the
  // command currently on the bus, so phase changes look at its last value.
  always_comb begin
    nx_state = state;
    nx_csb   = 1'b1;
    nx_web   = 1'b1;
    nx_addr  = mem_addr;
    nx_din   = mem_din;
    push     = 1'b0;
    flush    = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          nx_state = S_WRITE;
          nx_csb   = 1'b0;
          nx_web   = 1'b0;
          nx_addr  = '0;
          nx_din   = pat('0);
        end
      end
      S_WRITE: begin
        nx_csb = 1'b0;
        if (mem_addr == LAST) begin
          nx_state = S_READ;
          nx_addr  = '0;
          push     = 1'b1;
        end else begin
          nx_web  = 1'b0;
          nx_addr = mem_addr + 1'b1;
          nx_din  = pat(mem_addr + 1'b1);
        end
      end
      S_READ: begin
        if (mismatch) begin
          nx_state = S_RESULT;
          flush    = 1'b1;
        end else if (mem_addr == LAST) begin
          nx_state = S_DRAIN;
        end else begin
          nx_csb  = 1'b0;
          nx_addr = mem_addr + 1'b1;
          push    = 1'b1;
        end
      end
      S_DRAIN: begin
        if (mismatch) begin
          nx_state = S_RESULT;
          flush    = 1'b1;
        end else if (last_ok) begin
          nx_state = S_RESULT;
        end
      end
      S_RESULT: begin
        nx_state = S_IDLE;
      end
      default: begin
        nx_state = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      pipe_vld <= '0;
      for (int i = 0; i <= RD_LAT; i++) pipe_tag[i] <= '0;
    end else begin
      pipe_vld    <= {pipe_vld[RD_LAT-1:0], push};
      pipe_tag[0] <= nx_addr;
      for (int i = 1; i <= RD_LAT; i++) pipe_tag[i] <= pipe_tag[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mem_csb   <= 1'b1;
      mem_web   <= 1'b1;
      mem_addr  <= '0;
      mem_din   <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      fail      <= 1'b0;
      fail_addr <= '0;
      checkbits <= 16'h0000;
      blk       <= 1'b0;
    end else begin
      mem_csb  <= nx_csb;
      mem_web  <= nx_web;
      mem_addr <= nx_addr;
      mem_din  <= nx_din;
      busy     <= (nx_state == S_WRITE) || (nx_state == S_READ) || (nx_state == S_DRAIN);
      done     <= (nx_state == S_RESULT);
      if (state == S_IDLE && start) begin
        blk       <= block_sel;
        fail      <= 1'b0;
        fail_addr <= '0;
        checkbits <= block_sel ? B1_START : B0_START;
      end
      // Only the first mismatch is seen: the pipe is flushed on the same edge.
      if (mismatch) begin
        fail      <= 1'b1;
        fail_addr <= pipe_tag[RD_LAT];
        checkbits <= blk ? B1_FAIL : B0_FAIL;
      end else if (last_ok) begin
        checkbits <= blk ? B1_PASS : B0_PASS;
      end
    end
  end

endmodule

// File: tb/tb_storage_word_bist.sv
`timescale 1ns/1ps
// tb/tb_storage_word_bist.sv - self-checking bench for storage_word_bist (RD_LAT 1 and 3 side by side)

module tb_storage_word_bist;

  localparam int D = 256;

  logic clk = 1'b0;
  logic reset;
  logic start;
  logic block_sel;

  logic        csb [2];
  logic        web [2];
  logic [7:0]  maddr [2];
  logic [31:0] din [2];
  logic [31:0] dout [2];
  logic        busy [2];
  logic        done [2];
  logic        fail [2];
  logic [7:0]  faddr [2];
  logic [15:0] cb [2];

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  storage_word_bist #(.RD_LAT(1)) u_dut_l1 (
    .clk(clk), .reset(reset), .start(start), .block_sel(block_sel),
    .mem_csb(csb[0]), .mem_web(web[0]), .mem_addr(maddr[0]), .mem_din(din[0]),
    .mem_dout(dout[0]), .busy(busy[0]), .done(done[0]), .fail(fail[0]),
    .fail_addr(faddr[0]), .checkbits(cb[0])
  );

  storage_word_bist #(.RD_LAT(3)) u_dut_l3 (
    .clk(clk), .reset(reset), .start(start), .block_sel(block_sel),
    .mem_csb(csb[1]), .mem_web(web[1]), .mem_addr(maddr[1]), .mem_din(din[1]),
    .mem_dout(dout[1]), .busy(busy[1]), .done(done[1]), .fail(fail[1]),
    .fail_addr(faddr[1]), .checkbits(cb[1])
  );

  function automatic int lat(input int i);
    return (i == 0) ? 1 : 3;
  endfunction

  function automatic logic [31:0] ref_pat(input int a);
    return 32'hA5A5_0F0F + a * 32'h0101_0103;
  endfunction

  // kind: 0 start, 1 fail, 2 pass
  function automatic logic [15:0] code(input logic b, input int kind);
    logic [15:0] c;
    if (kind == 0)      c = b ? 16'hA020 : 16'hA040;
    else if (kind == 1) c = b ? 16'hAB20 : 16'hAB40;
    else                c = b ? 16'hAB21 : 16'hAB41;
    return c;
  endfunction

  // SRAM models: fault mode 0 none, 1 flip bit 0, 2 word reads as zero.
  int fmode = 0;
  int fa    = 0;
  logic [31:0] mem [2][D];
  logic [31:0] rq [2][3];

  function automatic logic [31:0] faulted(input logic [31:0] v, input int a);
    if (fmode == 1 && a == fa) return v ^ 32'h1;
    if (fmode == 2 && a == fa) return 32'h0;
    return v;
  endfunction

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (!csb[i] && !web[i]) mem[i][maddr[i]] <= din[i];
      if (!csb[i] && web[i]) rq[i][0] <= faulted(mem[i][maddr[i]], int'(maddr[i]));
      else                   rq[i][0] <= $urandom;
      rq[i][1] <= rq[i][0];
      rq[i][2] <= rq[i][1];
    end
  end
  assign dout[0] = rq[0][0];
  assign dout[1] = rq[1][2];

  // Bus monitor; statistics restart whenever the bench bumps run_id.
  int run_id = 0;
  int seen_id = 0;
  int wr_cnt [2], wr_bad [2], wr_next [2];
  int rd_cnt [2], rd_max [2], rd_after [2];
  int done_cnt [2], done_cyc [2];
  logic busy_at_done [2];

  always @(negedge clk) begin
    if (run_id != seen_id) begin
      seen_id = run_id;
      for (int i = 0; i < 2; i++) begin
        wr_cnt[i] = 0; wr_bad[i] = 0; wr_next[i] = 0;
        rd_cnt[i] = 0; rd_max[i] = -1; rd_after[i] = 0;
        done_cnt[i] = 0; done_cyc[i] = 0; busy_at_done[i] = 1'b1;
      end
    end
    for (int i = 0; i < 2; i++) begin
      if (!reset && !csb[i] && !web[i]) begin
        if (int'(maddr[i]) != wr_next[i] || din[i] !== ref_pat(wr_next[i])) wr_bad[i]++;
        wr_cnt[i]++;
        wr_next[i]++;
      end
      if (!reset && !csb[i] && web[i]) begin
        rd_cnt[i]++;
        if (int'(maddr[i]) > rd_max[i]) rd_max[i] = int'(maddr[i]);
        if (done_cnt[i] > 0) rd_after[i]++;
      end
      if (!reset && done[i]) begin
        done_cnt[i]++;
        done_cyc[i] = cyc;
        busy_at_done[i] = busy[i];
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("%s_L%0d_csb", tag, lat(i)), 32'(csb[i]), 32'd1);
      chk($sformatf("%s_L%0d_web", tag, lat(i)), 32'(web[i]), 32'd1);
      chk($sformatf("%s_L%0d_addr", tag, lat(i)), 32'(maddr[i]), 32'd0);
      chk($sformatf("%s_L%0d_din", tag, lat(i)), din[i], 32'd0);
      chk($sformatf("%s_L%0d_busy", tag, lat(i)), 32'(busy[i]), 32'd0);
      chk($sformatf("%s_L%0d_done", tag, lat(i)), 32'(done[i]), 32'd0);
      chk($sformatf("%s_L%0d_fail", tag, lat(i)), 32'(fail[i]), 32'd0);
      chk($sformatf("%s_L%0d_faddr", tag, lat(i)), 32'(faddr[i]), 32'd0);
      chk($sformatf("%s_L%0d_cb", tag, lat(i)), 32'(cb[i]), 32'h0000);
    end
  endtask

  // One complete test on both instances. poke >= 0 pulses start again
  // that many cycles into the run, while the engine is busy.
  task automatic run_test(input string tag, input logic b, input int mode, input int f, input int poke);
    int t0;
    int exp_lat, exp_rd_max;
    logic exp_fail;
    fmode = mode;
    fa    = f;
    run_id++;
    @(negedge clk);
    start = 1'b1;
    block_sel = b;
    @(negedge clk);
    start = 1'b0;
    block_sel = $urandom_range(0, 1);
    t0 = cyc;
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("%s_L%0d_start_cb", tag, lat(i)), 32'(cb[i]), 32'(code(b, 0)));
      chk($sformatf("%s_L%0d_start_busy", tag, lat(i)), 32'(busy[i]), 32'd1);
    end
    for (int k = 0; k < 1500 && !(done_cnt[0] > 0 && done_cnt[1] > 0); k++) begin
      @(negedge clk);
      start = (k == poke);
    end
    start = 1'b0;
    repeat (12) @(negedge clk);
    exp_fail = (mode != 0);
    for (int i = 0; i < 2; i++) begin
      // Cycles counted from the start cycle to the done cycle.
      exp_lat = exp_fail ? (D + f + lat(i) + 2) : (2 * D + lat(i) + 1);
      exp_rd_max = exp_fail ? ((f + lat(i) > D - 1) ? D - 1 : f + lat(i)) : D - 1;
      chk($sformatf("%s_L%0d_done_cnt", tag, lat(i)), 32'(done_cnt[i]), 32'd1);
      chk($sformatf("%s_L%0d_latency", tag, lat(i)), 32'(done_cyc[i] - t0 + 1), 32'(exp_lat));
      chk($sformatf("%s_L%0d_busy_at_done", tag, lat(i)), 32'(busy_at_done[i]), 32'd0);
      chk($sformatf("%s_L%0d_cb", tag, lat(i)), 32'(cb[i]), 32'(code(b, exp_fail ? 1 : 2)));
      chk($sformatf("%s_L%0d_fail", tag, lat(i)), 32'(fail[i]), 32'(exp_fail));
      chk($sformatf("%s_L%0d_faddr", tag, lat(i)), 32'(faddr[i]), exp_fail ? 32'(f) : 32'd0);
      chk($sformatf("%s_L%0d_wr_cnt", tag, lat(i)), 32'(wr_cnt[i]), 32'(D));
      chk($sformatf("%s_L%0d_wr_bad", tag, lat(i)), 32'(wr_bad[i]), 32'd0);
      chk($sformatf("%s_L%0d_rd_cnt", tag, lat(i)), 32'(rd_cnt[i]), 32'(exp_rd_max + 1));
      chk($sformatf("%s_L%0d_rd_max", tag, lat(i)), 32'(rd_max[i]), 32'(exp_rd_max));
      chk($sformatf("%s_L%0d_rd_after", tag, lat(i)), 32'(rd_after[i]), 32'd0);
      chk($sformatf("%s_L%0d_idle_busy", tag, lat(i)), 32'(busy[i]), 32'd0);
    end
  endtask

  initial begin
    int k;
    reset = 1'b1;
    start = 1'b0;
    block_sel = 1'b0;
    repeat (3) @(negedge clk);
    chk_reset_vals("rst");
    reset = 1'b0;

    // Reset in the middle of the write phase.
    run_id++;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (k = 0; k < 200 && maddr[0] != 8'h40; k++) @(negedge clk);
    chk("midwr_reach_40", 32'(maddr[0]), 32'h40);
    reset = 1'b1;
    @(negedge clk);
    chk_reset_vals("midwr");
    reset = 1'b0;
    run_test("after_rst", 1'b0, 0, 0, -1);

    run_test("pass_b0", 1'b0, 0, 0, -1);
    run_test("pass_b1", 1'b1, 0, 0, -1);
    run_test("flip_7f", 1'b0, 1, 8'h7F, -1);
    run_test("stuck_ff_poke", 1'($urandom_range(0, 1)), 2, 8'hFF, 300);

    // start and reset together: reset wins.
    @(negedge clk);
    reset = 1'b1;
    start = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    start = 1'b0;
    chk_reset_vals("rst_start");

    for (int r = 0; r < 4; r++) begin
      run_test($sformatf("rnd%0d", r), 1'($urandom_range(0, 1)),
               (r == 3) ? 0 : $urandom_range(1, 2), $urandom_range(0, D - 1), -1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
